// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and types for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 2;
  localparam int RF_NREGS  = 1 << RF_ADDR_W;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } pend_wr_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_PEND  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic favour1;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = favour1 ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // The requester just served loses priority to the other one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      favour1 <= 1'b0;
    end else if (accept) begin
      favour1 <= gnt[0];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates two write requesters into one register-file write port through a single pending slot.
// Optional RF_WB_BYPASS_EN adds read-port forwarding of the pending write.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
`ifdef RF_WB_BYPASS_EN
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  input  logic [DATA_W-1:0]        rf_data1,
  input  logic [DATA_W-1:0]        rf_data2,
  output logic [DATA_W-1:0]        byp_data1,
  output logic [DATA_W-1:0]        byp_data2,
`endif
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  input  logic                     rf_hold,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_addr3,
  output logic [DATA_W-1:0]        rf_data3,
  output logic [(1<<ADDR_W)-1:0]   busy_mask
);

  slot_state_t       state, state_next;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] pd;
  logic              pv;
  logic              slot_free;
  logic              accept;
  logic [1:0]        gnt;

  assign pv       = (state == SLOT_PEND);
  assign rf_write = pv && !rf_hold;
  assign rf_addr3 = pa;
  assign rf_data3 = pd;

  // Reset gates the grant so ready stays low while reset_n is held.
  assign slot_free = reset_n && !(pv && rf_hold);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid} & {2{slot_free}}),
    .accept  (accept),
    .gnt     (gnt)
  );

  assign accept     = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = SLOT_PEND;
    end else if (rf_write) begin
      state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pa <= '0;
      pd <= '0;
    end else if (accept) begin
      pa <= gnt[1] ? req1_addr : req0_addr;
      pd <= gnt[1] ? req1_data : req0_data;
    end
  end

  always_comb begin
    busy_mask = '0;
    if (pv) begin
      busy_mask[pa] = 1'b1;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_data1 = (pv && (pa == rd_addr1)) ? pd : rf_data1;
  assign byp_data2 = (pv && (pa == rd_addr2)) ? pd : rf_data2;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sets the register data width.
REQ-002 Parameter ADDR_W, default 2, sets the register address width (2^ADDR_W registers).
REQ-003 Clock and reset SHALL be: reset reset_n, asynchronous, active-low; clock clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req0_valid / req1_valid  in  1  write request from requester 0 / 1.
REQ-007 req0_addr / req1_addr  in  ADDR_W  target register.
REQ-008 req0_data / req1_data  in  DATA_W  write data.
REQ-009 req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready.
REQ-010 rf_hold  in  1  register file must not be written this cycle.
REQ-011 rf_write  out  1  write enable to the register file.
REQ-012 rf_addr3  out  ADDR_W  write address to the register file.
REQ-013 rf_data3  out  DATA_W  write data to the register file.
REQ-014 busy_mask  out  2^ADDR_W  bit i set while a write to register i is accepted but not yet committed.

Function
REQ-015 The block SHALL own one pending-write register (pv, pa, pd); states: EMPTY (pv=0) and PEND (pv=1).
REQ-016 rf_write SHALL equal pv && !rf_hold; rf_addr3=pa and rf_data3=pd at all times.
REQ-017 The pending write SHALL commit on a rising edge where rf_write=1.
REQ-018 The slot is free for a new accept when it is EMPTY, or when it is PEND and committing this cycle; ready SHALL be 0 for both requesters otherwise.
REQ-019 When the slot is free, only one requester valid: that requester's ready=1; neither valid: both ready=0.
REQ-020 When the slot is free and both are valid, grant round-robin: the requester not granted last wins; ready=1 only to the winner.
REQ-021 The round-robin pointer SHALL update only on an accepted request.
REQ-022 Accept SHALL load pa/pd from the winner on the same edge, giving PEND; latency from accept to rf_write is 1 cycle; sustained throughput is 1 write/cycle.
REQ-023 PEND with rf_hold=1 SHALL hold pa/pd unchanged; no data may be lost or duplicated.
REQ-024 ready SHALL be combinational from valid, pv, rf_hold, and the pointer; it SHALL NOT depend on req*_addr/data.
REQ-025 Both requesters targeting the same address SHALL be serviced as two separate writes in grant order; no merging.
REQ-026 busy_mask SHALL be the one-hot of pa when pv=1, else all zero.

Reset
REQ-027 reset_n=0 SHALL immediately force pv=0, rf_write=0, busy_mask=0, both ready=0, and the pointer to favour requester 0.
REQ-028 A pending write in flight at reset SHALL be discarded, never committed.
REQ-029 pa/pd SHALL reset to 0.

Configuration
REQ-030 With macro RF_WB_BYPASS_EN defined, the block SHALL add:
- inputs rd_addr1/rd_addr2 (ADDR_W) and rf_data1/rf_data2 (DATA_W)
- outputs byp_data1/byp_data2 (DATA_W), each equal to pd when pv=1 and pa matches its rd_addr, else the matching rf_data.
REQ-031 Without RF_WB_BYPASS_EN, those ports and that logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-032 A shared package SHALL hold RF_DATA_W=16, RF_ADDR_W=2, RF_NREGS=4, and the pending-write struct type (valid, addr, data).
REQ-033 One sub-module rr_arb2 (2-way round-robin arbiter: req[1:0], accept, gnt[1:0]) is natural; everything else is inline.

Verification
REQ-034 Reset, then req0 valid addr=1 data=0x1234 -> ready0=1 at cycle 0; cycle 1: rf_write=1, addr3=1, data3=0x1234, busy_mask=0010.
REQ-035 Both valid every cycle (req0 addr0 0xAAAA, req1 addr3 0x5555) -> grants alternate 0,1,0,1; rf_write every cycle from cycle 1.
REQ-036 PEND with rf_hold=1 for 3 cycles while req1 valid -> rf_write=0, ready1=0, addr3/data3 stable; after hold drops, old write commits and ready1=1 the same cycle.
REQ-037 Both requesters write addr2 (0x0001, 0x0002) in the same cycle -> two commits to addr2 in grant order; final register value = the later grant's data.
REQ-038 reset_n asserted mid-cycle while PEND -> rf_write drops without a clock edge; no commit after release; next grant goes to req0.
REQ-039 With RF_WB_BYPASS_EN, PEND addr1=0xBEEF, rd_addr1=1, rf_data1=0x0000 -> byp_data1=0xBEEF; rd_addr2=2 -> byp_data2=rf_data2.
